// File: rtl/r_int.sv
// CIC interpolator rate-change stage: passes one input sample on phase 0 and
// stuffs R-1 zeros behind it. The output is registered with one clock of latency.
module r_int #(
    parameter int Win = 19,
    parameter int R   = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  val_in,
    input  logic signed [Win-1:0] data_in,
    output logic                  val_out,
    output logic signed [Win-1:0] data_out
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

    logic [PW-1:0]         ph_q, ph_d;
    logic                  val_q, val_d;
    logic signed [Win-1:0] data_q, data_d;

    // The phase only advances while the stream is active, so a val_in gap
    // freezes it and the run resumes exactly where it stopped.
    always_comb begin
        ph_d   = ph_q;
        val_d  = 1'b0;
        data_d = '0;
        if (val_in) begin
            val_d = 1'b1;
            if (ph_q == '0) data_d = data_in;
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= '0;
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ph_q   <= ph_d;
            val_q  <= val_d;
            data_q <= data_d;
        end
    end

    assign val_out  = val_q;
    assign data_out = data_q;
endmodule

// File: tb/tb_r_int.sv
// Directed bench for r_int: a per-cycle vector table on an R=2 instance plus
// hand-written long-phase sequences on the default R=2000 instance.
module tb_r_int;
    localparam int W  = 19;
    localparam int RB = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_b, val_b, vo_b;
    logic signed [W-1:0] din_b, dout_b;
    logic                rst_s, val_s, vo_s;
    logic signed [W-1:0] din_s, dout_s;

    r_int #(.Win(W), .R(RB)) u_big (
        .clk(clk), .rst(rst_b), .val_in(val_b), .data_in(din_b),
        .val_out(vo_b), .data_out(dout_b)
    );

    r_int #(.Win(W), .R(2)) u_small (
        .clk(clk), .rst(rst_s), .val_in(val_s), .data_in(din_s),
        .val_out(vo_s), .data_out(dout_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic                rst;
        logic                val;
        logic signed [W-1:0] din;
        logic                e_val;
        logic signed [W-1:0] e_dout;
    } vec_t;

    vec_t vt[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic av, input logic signed [W-1:0] ad,
                       input logic ev, input logic signed [W-1:0] ed);
        n_cmp++;
        if (av !== ev || ad !== ed) begin
            n_err++;
            $display("FAIL %s: got val_out=%b data_out=%0d, want val_out=%b data_out=%0d",
                     nm, av, ad, ev, ed);
        end
    endtask

    // n active cycles with junk on data_in; the junk must never reach the output.
    task automatic run_zeros(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            val_b = 1'b1;
            din_b = W'($urandom) | W'(1);
            step();
            chk(nm, vo_b, dout_b, 1'b1, '0);
        end
    endtask

    task automatic sample(input logic signed [W-1:0] s, input string nm);
        val_b = 1'b1;
        din_b = s;
        step();
        chk(nm, vo_b, dout_b, 1'b1, s);
    endtask

    logic signed [W-1:0] stream[20];

    initial begin
        rst_b = 1'b1; val_b = 1'b0; din_b = '0;
        rst_s = 1'b1; val_s = 1'b0; din_s = '0;

        // R=2 table: {rst, val_in, data_in, expected val_out, expected data_out}
        vt[0]  = '{1'b1, 1'b0, 19'sd0,      1'b0, 19'sd0};
        vt[1]  = '{1'b1, 1'b1, 19'sd9,      1'b0, 19'sd0};      // rst beats val_in
        vt[2]  = '{1'b0, 1'b1, 19'sd5,      1'b1, 19'sd5};
        vt[3]  = '{1'b0, 1'b1, 19'sd99,     1'b1, 19'sd0};
        vt[4]  = '{1'b0, 1'b1, -19'sd3,     1'b1, -19'sd3};
        vt[5]  = '{1'b0, 1'b1, 19'sd77,     1'b1, 19'sd0};
        vt[6]  = '{1'b0, 1'b1, -19'sd262144, 1'b1, -19'sd262144};
        vt[7]  = '{1'b0, 1'b0, 19'sd55,     1'b0, 19'sd0};      // gap, ph frozen at 1
        vt[8]  = '{1'b0, 1'b1, 19'sd66,     1'b1, 19'sd0};
        vt[9]  = '{1'b0, 1'b1, 19'sd262143, 1'b1, 19'sd262143};
        vt[10] = '{1'b1, 1'b1, 19'sd4,      1'b0, 19'sd0};      // reset mid-run at ph=1
        vt[11] = '{1'b0, 1'b1, 19'sd0,      1'b1, 19'sd0};      // zero sample
        vt[12] = '{1'b0, 1'b1, 19'sd8,      1'b1, 19'sd0};
        vt[13] = '{1'b0, 1'b1, 19'sd8,      1'b1, 19'sd8};

        for (int i = 0; i < 14; i++) begin
            rst_s = vt[i].rst; val_s = vt[i].val; din_s = vt[i].din;
            step();
            chk($sformatf("small_vec%0d", i), vo_s, dout_s, vt[i].e_val, vt[i].e_dout);
        end

        // Reset with val_in low for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset", vo_b, dout_b, 1'b0, '0);
        end

        // Single sample, hold check at ph=5, then the wrap samples again.
        rst_b = 1'b0;
        sample(19'sd1234, "single");
        run_zeros(4, "single_zero");
        val_b = 1'b1; din_b = 19'sd777;
        step();
        chk("hold_777", vo_b, dout_b, 1'b1, '0);
        run_zeros(RB - 6, "single_zero");

        // Sample stream, each sample on its phase-0 cycle.
        stream = '{19'sd0, 19'sd131071, -19'sd131072, 19'sd262143, -19'sd262144,
                   19'sd1, -19'sd1, 19'sd1000, -19'sd5000, 19'sd42,
                   19'sd65536, -19'sd65537, 19'sd12345, -19'sd54321, 19'sd7,
                   19'sd0, 19'sd200000, -19'sd200000, 19'sd3, -19'sd2};
        for (int i = 0; i < 20; i++) begin
            sample(stream[i], $sformatf("stream_s%0d", i));
            run_zeros(RB - 1, $sformatf("stream_z%0d", i));
        end

        // val_in dropped for 3 cycles at ph=300; resume from the frozen phase.
        sample(19'sd4444, "gap_first");
        run_zeros(299, "gap_pre");
        for (int i = 0; i < 3; i++) begin
            val_b = 1'b0; din_b = 19'sd321;
            step();
            chk("gap_off", vo_b, dout_b, 1'b0, '0);
        end
        run_zeros(RB - 300, "gap_post");
        sample(-19'sd4444, "gap_next");

        // Reset pulse at ph=700 with val_in still high, then restart at phase 0.
        run_zeros(699, "rst_pre");
        rst_b = 1'b1; val_b = 1'b1; din_b = 19'sd999;
        step();
        chk("rst_mid", vo_b, dout_b, 1'b0, '0);
        rst_b = 1'b0;
        sample(19'sd4321, "rst_restart");
        run_zeros(5, "rst_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/r_int.md
# r_int

Rate-change (zero-stuffing) stage of the CIC interpolator chain, between the comb section and the integrator section. It accepts one signed sample every R clock cycles and emits a full-rate stream at one sample per clock. Each input sample appears once, followed by R-1 zeros. Output is registered, with one clock of latency.

## Interface
Parameters:
- Win, default 19: data width in bits, for both input and output (signed two's complement).
- R, default 2000: interpolation factor, i.e. output samples per input sample. Must be ≥ 2.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- val_in  input  1  stream-active qualifier; held high for the whole interpolation run.
- data_in  input  Win  signed input sample from the comb stage. Sampled only on phase-0 cycles.
- val_out  output  1  output-valid flag; registered copy of val_in.
- data_out  output  Win  signed interpolated sample to the integrator stage.

## Operation
- Internal phase counter `ph`, width ceil(log2(R)), range 0..R-1.
- On a rising edge with rst=1:
  - ph ← 0, val_out ← 0, data_out ← 0.
  - rst takes priority over val_in.
- On a rising edge with rst=0 and val_in=1:
  - If ph==0: data_out ← data_in. Otherwise: data_out ← 0.
  - ph ← (ph==R-1) ? 0 : ph+1. The counter wraps, with no saturation.
  - val_out ← 1.
- On a rising edge with rst=0 and val_in=0:
  - ph holds its value.
  - data_out ← 0, val_out ← 0.
  - A later rise of val_in resumes from the held phase.
- Arithmetic:
  - No gain or scaling; the input sample passes through bit-exact.
  - No sign extension or truncation; widths are equal.
  - The zero is an all-zero Win-bit word.
- Upstream contract: the source presents a new data_in aligned with ph==0. This is the first val_in=1 cycle after reset, and then every R cycles. data_in on other cycles is ignored.

## Timing
- Latency: data_in sampled at edge k (ph==0) appears on data_out after edge k, so it is visible during cycle k+1.
- Output pattern per input sample: 1 cycle carrying the sample, then R-1 cycles of 0. val_out is 1 on all R cycles.
- Throughput: one output word per clock while val_in=1. There is no backpressure.
- Reset values: val_out=0, data_out=0, ph=0.
- Boundary conditions:
  - R-1 → 0 wrap: the first cycle after the wrap samples data_in again.
  - Reset mid-run:
    - Outputs clear on the next edge.
    - The phase restarts at 0 on the first val_in=1 cycle after rst is released.
  - val_in deasserted mid-run: outputs go to 0 and val_out=0 one edge later. The phase is frozen.
  - Input sample equal to 0: output is 0 on all R cycles, and val_out is still 1.
  - Extreme inputs pass unchanged:
    - Negative full scale −2^(Win−1), e.g. 19'h40000.
    - Positive full scale 2^(Win−1)−1.

## Test plan
- Reset check:
  - Stimulus: rst=1 for 10 cycles with val_in=0.
  - Required: val_out=0 and data_out=0 every cycle.
- Single sample:
  - Stimulus: release rst, val_in=1, data_in=19'sd1234 on the first cycle.
  - Required:
    - data_out=1234 on the cycle after the first active edge, then 0 for 1999 cycles.
    - val_out=1 throughout.
- Sample stream:
  - Stimulus: 51 input samples, each presented on its phase-0 cycle, 2000 cycles apart. Values include 0, +131071 and −131072.
  - Required: 102000 output cycles that match a zero-stuffed golden file bit-exactly, with 0 mismatches.
- Hold check:
  - Stimulus: change data_in on non-phase-0 cycles, e.g. to 19'sd777 at ph=5.
  - Required: data_out stays 0 on those cycles; the value is ignored.
- Mid-run disruption:
  - Stimulus: pulse rst at ph=700, then restart.
  - Required:
    - Outputs are 0 on the edge after rst.
    - The next val_in cycle samples data_in as phase 0.
  - Stimulus: drop val_in for 3 cycles at ph=300.
  - Required:
    - val_out=0 and data_out=0 for those 3 cycles.
    - Resume at ph=300, so the next sample is taken 1700 active cycles later.
- Small R:
  - Stimulus: R=2, input sequence 5, −3.
  - Required: output sequence 5, 0, −3, 0.
